// File: rtl/fgmt.sv
// Shared types for the fine-grained multithreaded fetch front end:
// word/line widths, thread ID width and the L2 request record.
package fgmt;

    localparam int TID_bits         = 2;
    localparam int WORD_BITS        = 32;
    localparam int LINE_BITS        = 128;
    localparam int LINE_OFFSET_BITS = 4;

    localparam logic set   = 1'b1;
    localparam logic clear = 1'b0;

    typedef logic [WORD_BITS-1:0] word;
    typedef logic [LINE_BITS-1:0] line;
    typedef logic [TID_bits-1:0]  tid_t;

    typedef struct packed {
        tid_t tid;
        word  addr;
    } l2_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } arb_state_t;

    function automatic word line_align(input word a);
        return {a[WORD_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

    // Line after the one holding a; the line index wraps at the top of memory.
    function automatic word next_line(input word a);
        logic [WORD_BITS-LINE_OFFSET_BITS-1:0] idx;
        idx = a[WORD_BITS-1:LINE_OFFSET_BITS] + (WORD_BITS-LINE_OFFSET_BITS)'(1);
        return {idx, {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_request_arbiter_fifo.sv
// In-flight L2 request tracker: synchronous FIFO of l2_req_t records,
// head visible combinationally, power-of-two DEPTH >= 2.
module l2_req_fifo
    import fgmt::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  l2_req_t push_data,
    input  logic    pop,
    output l2_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_BITS = $clog2(DEPTH);

    l2_req_t             mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (PTR_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_BITS+1)'(1);
                2'b01:   count <= count - (PTR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter between per-thread L1 I-cache request sources and the L2,
// with in-flight tracking and in-order response routing back to the owner thread.
module l2_request_arbiter
    import fgmt::*;
#(
    parameter int NUM_THREADS = 2**TID_bits,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_THREADS-1:0] br_req_i,
    input  logic [NUM_THREADS-1:0] req_refill_i,
    input  logic [NUM_THREADS-1:0] req_spec_i,
    input  word  [NUM_THREADS-1:0] pc_i,
    input  word  [NUM_THREADS-1:0] br_target_i,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output word                   mem_req_addr,
    output tid_t                  mem_req_tid,
    input  logic                  mem_rsp_valid,
    input  line                   mem_rsp_data,
    output logic                  rsp_valid,
    output line                   l2_cache_block_rsp,
    output word                   PC_L2_i,
    output tid_t                  tid_from_l2,
    output logic                  err_o
);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [NUM_THREADS-1:0] pending;
    logic [NUM_THREADS-1:0] eligible;
    word  [NUM_THREADS-1:0] thread_addr;
    tid_t                   rr_ptr;
    tid_t                   grant_tid;
    logic                   any_eligible;
    logic                   grant;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    l2_req_t                head;

    // NOTE: every output of a combinational block gets a value on every path, so no latches.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = (br_req_i[t] | req_refill_i[t] | req_spec_i[t]) & ~pending[t];
            if (br_req_i[t])          thread_addr[t] = line_align(br_target_i[t]);
            else if (req_refill_i[t]) thread_addr[t] = line_align(pc_i[t]);
            else                      thread_addr[t] = next_line(pc_i[t]);
        end
    end

    // Search starts one past the last winner so each thread gets a turn.
    always_comb begin
        tid_t idx;
        any_eligible = 1'b0;
        grant_tid    = rr_ptr;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx = tid_t'((int'(rr_ptr) + k) % NUM_THREADS);
            if (!any_eligible && eligible[idx]) begin
                any_eligible = 1'b1;
                grant_tid    = idx;
            end
        end
    end

    assign grant = (state == ARB_IDLE) && any_eligible && !fifo_full;
    assign pop   = mem_rsp_valid && !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (grant)         state_next = ARB_ISSUE;
            ARB_ISSUE: if (mem_req_ready) state_next = ARB_IDLE;
            default:                      state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = (state == ARB_ISSUE);
        push          = (state == ARB_ISSUE) && mem_req_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_addr       <= '0;
            mem_req_tid        <= '0;
            rr_ptr             <= tid_t'(NUM_THREADS - 1);
            pending            <= '0;
            rsp_valid          <= 1'b0;
            l2_cache_block_rsp <= '0;
            PC_L2_i            <= '0;
            tid_from_l2        <= '0;
            err_o              <= 1'b0;
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                l2_cache_block_rsp <= mem_rsp_data;
                PC_L2_i            <= head.addr;
                tid_from_l2        <= head.tid;
                pending[head.tid]  <= clear;
            end
            if (mem_rsp_valid && fifo_empty) err_o <= set;
            // A pending thread is masked, so the grant never collides with the clear above.
            if (grant) begin
                mem_req_addr       <= thread_addr[grant_tid];
                mem_req_tid        <= grant_tid;
                rr_ptr             <= grant_tid;
                pending[grant_tid] <= set;
            end
        end
    end

    l2_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data('{tid: mem_req_tid, addr: mem_req_addr}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule
